// File: rtl/bcd_digit_entry.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_entry
//  Description : Debounced, one-digit-per-press entry stage placed after the
//                decimal-to-BCD priority encoder. Accepted digits are shifted
//                into an N-digit packed-BCD register, newest digit in [3:0].
//                Optional build macro BCD_DIGIT_CHECK_EN rejects codes > 9
//                or codes with unknown bits (pulses bcd_err instead).
//                NUM_DIGITS and DEBOUNCE_CYCLES must both be >= 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_entry #(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            key_active,
  input  logic [3:0]                      bcd_in,
  input  logic                            clear,
  output logic [4*NUM_DIGITS-1:0]         value,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  output logic                            full,
  output logic [3:0]                      digit_out,
  output logic                            digit_strobe,
  output logic                            overflow,
  output logic                            bcd_err
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DEB_W-1:0] DEB_ZERO = '0;
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  // Counter value seen on the edge that completes a debounce window.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);
  localparam bit               DEB_SINGLE = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t             state_q,     state_d;
  logic [DEB_W-1:0]   deb_cnt_q,   deb_cnt_d;
  logic [3:0]         cand_q,      cand_d;
  logic [VAL_W-1:0]   value_q,     value_d;
  logic [CNT_W-1:0]   count_q,     count_d;
  logic [3:0]         digit_out_q, digit_out_d;
  logic               strobe_q,    strobe_d;
  logic               ovf_q,       ovf_d;
  logic               err_q,       err_d;

  // Accept strobe from the FSM (the edge on which a debounced press lands).
  logic               accept;
  // Candidate rejected by the optional code check.
  logic               code_bad;
  // Entry register with the candidate shifted into the newest position.
  logic [VAL_W-1:0]   shifted;
  logic               is_full;

  assign is_full = (count_q == CNT_FULL);

  // A single-digit register has no older digits to keep.
  generate
    if (NUM_DIGITS == 1) begin : g_shift_single
      assign shifted = cand_d;
    end else begin : g_shift_multi
      assign shifted = {value_q[VAL_W-5:0], cand_d};
    end
  endgenerate

`ifdef BCD_DIGIT_CHECK_EN
  // Reject non-decimal codes and codes that are not fully resolved.
  assign code_bad = $isunknown(cand_d) || (cand_d > 4'd9);
`else
  assign code_bad = 1'b0;
`endif

  // Debounce FSM: next state, counter, candidate capture and accept strobe.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    cand_d    = cand_q;
    accept    = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_active) begin
          cand_d    = bcd_in;
          deb_cnt_d = DEB_ONE;
          if (DEB_SINGLE) begin
            // One stable sample is already a full debounce window.
            accept  = 1'b1;
            state_d = HELD;
          end else begin
            state_d = DEB_PRESS;
          end
        end
      end

      DEB_PRESS: begin
        if (!key_active) begin
          state_d   = IDLE;
          deb_cnt_d = DEB_ZERO;
        end else if (bcd_in != cand_q) begin
          // Code moved under a held key: restart the window on the new code.
          cand_d    = bcd_in;
          deb_cnt_d = DEB_ONE;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
          accept    = 1'b1;
          state_d   = HELD;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
      end

      HELD: begin
        // bcd_in is deliberately ignored here; only the release matters.
        if (!key_active) begin
          deb_cnt_d = DEB_ONE;
          state_d   = DEB_SINGLE ? IDLE : DEB_RELEASE;
        end
      end

      DEB_RELEASE: begin
        if (key_active) begin
          state_d = HELD;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
          state_d   = IDLE;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
      end

      default: begin
        state_d   = IDLE;
        deb_cnt_d = DEB_ZERO;
      end
    endcase
  end

  // Entry register update: clear beats an accept landing on the same edge.
  always_comb begin
    value_d     = value_q;
    count_d     = count_q;
    digit_out_d = digit_out_q;
    strobe_d    = 1'b0;
    ovf_d       = 1'b0;
    err_d       = 1'b0;

    if (clear) begin
      value_d = '0;
      count_d = '0;
    end else if (accept) begin
      if (code_bad) begin
        err_d = 1'b1;
      end else if (is_full) begin
        ovf_d = 1'b1;
      end else begin
        value_d     = shifted;
        count_d     = count_q + CNT_W'(1);
        digit_out_d = cand_d;
        strobe_d    = 1'b1;
      end
    end
  end

  // All state registers; reset overrides any press in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      deb_cnt_q   <= DEB_ZERO;
      cand_q      <= 4'd0;
      value_q     <= '0;
      count_q     <= '0;
      digit_out_q <= 4'd0;
      strobe_q    <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      cand_q      <= cand_d;
      value_q     <= value_d;
      count_q     <= count_d;
      digit_out_q <= digit_out_d;
      strobe_q    <= strobe_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign value        = value_q;
  assign digit_count  = count_q;
  assign full         = is_full;
  assign digit_out    = digit_out_q;
  assign digit_strobe = strobe_q;
  assign overflow     = ovf_q;
  assign bcd_err      = err_q;

endmodule
`default_nettype wire
